booth_mac_seq: RTL and testbench

//   Sequential radix-2 Booth multiply-accumulate unit; successor of the combinational Booth multiplier.

---
 rtl/booth_mac_seq.sv | 133 +++++++++++++
 tb/tb_booth_mac_seq.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/booth_mac_seq.sv
// Sequential radix-2 Booth multiply-accumulate unit.
// One Booth step per clock behind a start/done handshake; the finished
// product either overwrites or saturating-adds into the result register.
module booth_mac_seq #(
    parameter int DATA_WIDTH = 9,
    parameter int ACC_WIDTH  = 2*DATA_WIDTH+4
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  start_in,
    input  logic                  acc_en_in,
    input  logic                  clr_acc_in,
    input  logic [DATA_WIDTH-1:0] multiplicando_in,
    input  logic [DATA_WIDTH-1:0] multiplicador_in,
    output logic                  busy_out,
    output logic                  done_out,
    output logic [ACC_WIDTH-1:0]  resultado_out,
    output logic                  flag_out
);

    localparam int CW = $clog2(DATA_WIDTH+1);

    localparam logic [ACC_WIDTH-1:0] SAT_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    localparam logic [ACC_WIDTH-1:0] SAT_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t state, state_nxt;

    // A and M carry one extra bit so negating the most negative multiplicand is exact
    logic [DATA_WIDTH:0]   a_reg, m_reg;
    logic [DATA_WIDTH-1:0] q_reg;
    logic                  q_m1;
    logic [CW-1:0]         count;
    logic                  acc_en_reg;

    logic [DATA_WIDTH:0]     a_sum, a_shift;
    logic [DATA_WIDTH-1:0]   q_shift;
    logic [2*DATA_WIDTH-1:0] prod_raw;
    logic [ACC_WIDTH-1:0]    product;
    logic [ACC_WIDTH:0]      sum;

    assign busy_out = (state != IDLE);

    // State register
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state: count is checked before its decrement, so 1 means last step
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start_in) state_nxt = CALC;
            CALC:    if (count == CW'(1)) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // One Booth step: conditional add/subtract of M, then arithmetic right shift of {A,Q,Q-1}
    always_comb begin
        a_sum = a_reg;
        case ({q_reg[0], q_m1})
            2'b01:   a_sum = a_reg + m_reg;
            2'b10:   a_sum = a_reg - m_reg;
            default: a_sum = a_reg;
        endcase
        a_shift = {a_sum[DATA_WIDTH], a_sum[DATA_WIDTH:1]};
        q_shift = {a_sum[0], q_reg[DATA_WIDTH-1:1]};
    end

    // Product truncated to 2*DATA_WIDTH bits, sign-extended; accumulate one bit wider to see overflow
    always_comb begin
        prod_raw = {a_reg[DATA_WIDTH-1:0], q_reg};
        product  = ACC_WIDTH'($signed(prod_raw));
        sum      = {resultado_out[ACC_WIDTH-1], resultado_out} + {product[ACC_WIDTH-1], product};
    end

    // Datapath, result register and sticky saturation flag
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            a_reg         <= '0;
            m_reg         <= '0;
            q_reg         <= '0;
            q_m1          <= 1'b0;
            count         <= '0;
            acc_en_reg    <= 1'b0;
            done_out      <= 1'b0;
            resultado_out <= '0;
            flag_out      <= 1'b0;
        end else begin
            done_out <= 1'b0;
            case (state)
                IDLE: begin
                    // Clear takes effect even when a start arrives on the same edge
                    if (clr_acc_in) begin
                        resultado_out <= '0;
                        flag_out      <= 1'b0;
                    end
                    if (start_in) begin
                        m_reg      <= {multiplicando_in[DATA_WIDTH-1], multiplicando_in};
                        a_reg      <= '0;
                        q_reg      <= multiplicador_in;
                        q_m1       <= 1'b0;
                        count      <= CW'(DATA_WIDTH);
                        acc_en_reg <= acc_en_in;
                    end
                end
                CALC: begin
                    a_reg <= a_shift;
                    q_reg <= q_shift;
                    q_m1  <= q_reg[0];
                    count <= count - CW'(1);
                end
                DONE: begin
                    done_out <= 1'b1;
                    if (!acc_en_reg) begin
                        resultado_out <= product;
                    end else if (sum[ACC_WIDTH] != sum[ACC_WIDTH-1]) begin
                        resultado_out <= sum[ACC_WIDTH] ? SAT_MIN : SAT_MAX;
                        flag_out      <= 1'b1;
                    end else begin
                        resultado_out <= sum[ACC_WIDTH-1:0];
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_booth_mac_seq.sv
// Directed self-checking bench for booth_mac_seq (DATA_WIDTH=9, ACC_WIDTH=22).
module tb_booth_mac_seq;

    localparam int DW = 9;
    localparam int AW = 2*DW+4;

    logic          clk_in = 1'b0;
    logic          rst_in = 1'b1;
    logic          start_in = 1'b0;
    logic          acc_en_in = 1'b0;
    logic          clr_acc_in = 1'b0;
    logic [DW-1:0] multiplicando_in = '0;
    logic [DW-1:0] multiplicador_in = '0;
    logic          busy_out, done_out, flag_out;
    logic [AW-1:0] resultado_out;

    int checks = 0;
    int failures = 0;

    booth_mac_seq #(.DATA_WIDTH(DW), .ACC_WIDTH(AW)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .start_in(start_in), .acc_en_in(acc_en_in),
        .clr_acc_in(clr_acc_in), .multiplicando_in(multiplicando_in),
        .multiplicador_in(multiplicador_in), .busy_out(busy_out), .done_out(done_out),
        .resultado_out(resultado_out), .flag_out(flag_out)
    );

    always #5 clk_in = ~clk_in;

    task automatic chk(input string tag, input longint obs, input longint exp);
        checks++;
        if (obs != exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, obs, exp);
        end
    endtask

    function automatic longint res_s();
        return longint'($signed(resultado_out));
    endfunction

    // Start one op, then watch until done_out; lat counts edges after the start edge
    task automatic run_op(input int a, input int b, input bit acc, input bit clr,
                          output int lat, output int busy_cnt);
        @(negedge clk_in);
        start_in = 1'b1; acc_en_in = acc; clr_acc_in = clr;
        multiplicando_in = DW'(a); multiplicador_in = DW'(b);
        @(posedge clk_in); #1;
        start_in = 1'b0; clr_acc_in = 1'b0;
        lat = 0; busy_cnt = 0;
        while (lat < 40) begin
            if (busy_out) busy_cnt++;
            @(posedge clk_in); #1;
            lat++;
            if (done_out) break;
        end
    endtask

    // Full handshake check of one op plus the one-cycle width of done_out
    task automatic op_chk(input string tag, input int a, input int b, input bit acc,
                          input bit clr, input longint exp_res, input bit exp_flag);
        int lat, bc;
        run_op(a, b, acc, clr, lat, bc);
        chk({tag, "_latency"}, lat, 10);
        chk({tag, "_busy_cycles"}, bc, 10);
        chk({tag, "_result"}, res_s(), exp_res);
        chk({tag, "_flag"}, flag_out, exp_flag);
        @(posedge clk_in); #1;
        chk({tag, "_done_pulse_width"}, done_out, 0);
    endtask

    task automatic do_clr();
        @(negedge clk_in); clr_acc_in = 1'b1;
        @(posedge clk_in); #1; clr_acc_in = 1'b0;
        chk("clr_result", res_s(), 0);
        chk("clr_flag", flag_out, 0);
    endtask

    initial begin
        int lat, bc, pulses;

        // 1. reset state and basic multiply
        repeat (2) @(posedge clk_in);
        #1;
        chk("rst_busy", busy_out, 0);
        chk("rst_done", done_out, 0);
        chk("rst_result", res_s(), 0);
        chk("rst_flag", flag_out, 0);
        @(negedge clk_in); rst_in = 1'b0;
        op_chk("mul_3x-2", 3, -2, 1'b0, 1'b0, -6, 1'b0);

        // 2. corners
        op_chk("mul_-256x-256", -256, -256, 1'b0, 1'b0, 65536, 1'b0);
        op_chk("mul_-256x255", -256, 255, 1'b0, 1'b0, -65280, 1'b0);
        op_chk("mul_0x-5", 0, -5, 1'b0, 1'b0, 0, 1'b0);
        op_chk("mul_255x255", 255, 255, 1'b0, 1'b0, 65025, 1'b0);

        // 3. accumulate then overwrite
        do_clr();
        op_chk("acc_3x2", 3, 2, 1'b1, 1'b0, 6, 1'b0);
        op_chk("acc_4x5", 4, 5, 1'b1, 1'b0, 26, 1'b0);
        op_chk("mul_7x-1", 7, -1, 1'b0, 1'b0, -7, 1'b0);
        // clear together with start: accumulation starts from 0
        op_chk("clr_start_acc", 3, 2, 1'b1, 1'b1, 6, 1'b0);

        // 4. positive saturation
        do_clr();
        for (int i = 1; i <= 33; i++) begin
            run_op(-256, -256, 1'b1, 1'b0, lat, bc);
            if (i == 31) begin
                chk("sat_op31_result", res_s(), 2031616);
                chk("sat_op31_flag", flag_out, 0);
            end
            if (i == 32) begin
                chk("sat_op32_result", res_s(), 2097151);
                chk("sat_op32_flag", flag_out, 1);
            end
            if (i == 33) begin
                chk("sat_op33_result", res_s(), 2097151);
                chk("sat_op33_flag", flag_out, 1);
            end
        end
        // multiply mode leaves the sticky flag alone
        op_chk("mul_after_sat", 7, -1, 1'b0, 1'b0, -7, 1'b1);
        do_clr();

        // negative saturation
        for (int i = 1; i <= 33; i++) begin
            run_op(-256, 255, 1'b1, 1'b0, lat, bc);
            if (i == 32) begin
                chk("nsat_op32_result", res_s(), -2088960);
                chk("nsat_op32_flag", flag_out, 0);
            end
            if (i == 33) begin
                chk("nsat_op33_result", res_s(), -2097152);
                chk("nsat_op33_flag", flag_out, 1);
            end
        end
        do_clr();

        // 5. start held high with changing operands while busy
        @(negedge clk_in);
        start_in = 1'b1; acc_en_in = 1'b0;
        multiplicando_in = DW'(5); multiplicador_in = DW'(-3);
        @(posedge clk_in); #1;
        lat = 0; pulses = 0;
        while (lat < 10) begin
            multiplicando_in = DW'($urandom_range(0, 511));
            multiplicador_in = DW'($urandom_range(0, 511));
            acc_en_in = 1'($urandom_range(0, 1));
            clr_acc_in = 1'($urandom_range(0, 1));
            @(posedge clk_in); #1;
            lat++;
            if (done_out) pulses++;
        end
        start_in = 1'b0; clr_acc_in = 1'b0;
        chk("busy_start_result", res_s(), -15);
        for (int i = 0; i < 12; i++) begin
            @(posedge clk_in); #1;
            if (done_out) pulses++;
        end
        chk("busy_start_pulses", pulses, 1);
        chk("busy_start_idle", busy_out, 0);

        // 6. reset during CALC
        @(negedge clk_in);
        start_in = 1'b1; acc_en_in = 1'b0;
        multiplicando_in = DW'(9); multiplicador_in = DW'(9);
        @(posedge clk_in); #1;
        start_in = 1'b0;
        repeat (4) @(posedge clk_in);
        #1;
        rst_in = 1'b1;
        #1;
        chk("midrst_busy", busy_out, 0);
        chk("midrst_done", done_out, 0);
        chk("midrst_result", res_s(), 0);
        chk("midrst_flag", flag_out, 0);
        @(negedge clk_in); rst_in = 1'b0;
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk_in); #1;
            if (done_out) pulses++;
        end
        chk("midrst_no_done", pulses, 0);
        chk("midrst_result_held", res_s(), 0);
        op_chk("post_rst_3x-2", 3, -2, 1'b0, 1'b0, -6, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
